bitscan_encoder: RTL and testbench

Parametrised sequential successor to the team's 8-to-3 combinational encoder.
- Accepts an N-bit one-hot or multi-hot vector through a valid/ready handshake.
- Emits the index of every set bit, one per output handshake, lowest-first or highest-first.
- Used to serialise interrupt/request vectors into indices for downstream arbiters and loggers.

---
 rtl/bitscan_pkg.sv | 19 +
 rtl/prio_enc_n.sv | 15 +
 rtl/bitscan_encoder.sv | 56 +++++
 tb/tb_bitscan_encoder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/bitscan_pkg.sv
// bitscan_pkg: shared state type and bit-scan helpers for the bitscan encoder family.
package bitscan_pkg;
  typedef enum logic {IDLE, SCAN} state_t;
  localparam int MAX_N = 256;
  function automatic int first_set(input logic [MAX_N-1:0] vec, input int n, input bit msb_first);
    int j;
    first_set = 0;
    // The last hit wins, so the walk runs opposite to the scan order.
    for (int i = 0; i < MAX_N; i++) begin
      j = msb_first ? i : MAX_N - 1 - i;
      if (j < n && vec[j]) first_set = j;
    end
  endfunction
  function automatic int popcount(input logic [MAX_N-1:0] vec, input int n);
    popcount = 0;
    for (int i = 0; i < MAX_N; i++)
      if (i < n) popcount += int'(vec[i]);
  endfunction
endpackage

// File: rtl/prio_enc_n.sv
// prio_enc_n: parametrised priority encoder, generalised replacement for the fixed 8-to-3 encoder.
module prio_enc_n
  import bitscan_pkg::*;
#(
  parameter int N = 8,
  parameter bit MSB_FIRST = 0,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         nonzero
);
  assign idx = W'(first_set(MAX_N'(vec), N, MSB_FIRST));
  assign nonzero = |vec;
endmodule

// File: rtl/bitscan_encoder.sv
// bitscan_encoder: accepts a request vector and emits the index of each set bit, one per handshake.
module bitscan_encoder
  import bitscan_pkg::*;
#(
  parameter int N = 8,
  parameter bit MSB_FIRST = 0,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic [W:0]   out_remain,
  output logic         zero_drop
);
  state_t state;
  logic [N-1:0] vec_q;
  logic [W-1:0] idx;
  logic any;
  prio_enc_n #(.N(N), .MSB_FIRST(MSB_FIRST)) u_prio (
    .vec(vec_q),
    .idx(idx),
    .nonzero(any)
  );
  assign in_ready = state == IDLE;
  assign out_valid = state == SCAN && any;
  assign out_idx = out_valid ? idx : '0;
  assign out_remain = out_valid ? (W+1)'(popcount(MAX_N'(vec_q), N)) : '0;
  assign out_last = out_valid && out_remain == (W+1)'(1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      vec_q <= '0;
      zero_drop <= 1'b0;
    end else begin
      zero_drop <= 1'b0;
      if (state == IDLE) begin
        if (in_valid && |in_vec) begin
          vec_q <= in_vec;
          state <= SCAN;
        end else if (in_valid) begin
          zero_drop <= 1'b1;
        end
      end else if (out_ready) begin
        // Retiring the last bit leaves vec_q at zero, so outputs read 0 in IDLE.
        vec_q <= vec_q & ~(N'(1) << idx);
        if (out_last) state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_bitscan_encoder.sv
// tb_bitscan_encoder: scoreboard bench for an N=8 LSB-first and an N=16 MSB-first encoder.
module tb_bitscan_encoder;
  typedef struct {int idx; int rem; bit last;} beat_t;
  logic clk = 0, rst_n = 0;
  logic a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 1, a_out_last, a_zero_drop;
  logic [7:0] a_in_vec = '0;
  logic [2:0] a_out_idx;
  logic [3:0] a_out_remain;
  logic b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 1, b_out_last, b_zero_drop;
  logic [15:0] b_in_vec = '0;
  logic [3:0] b_out_idx;
  logic [4:0] b_out_remain;
  int checks = 0, errors = 0;
  beat_t qa[$], qb[$];

  bitscan_encoder #(.N(8), .MSB_FIRST(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_vec(a_in_vec),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_idx(a_out_idx), .out_last(a_out_last),
    .out_remain(a_out_remain), .zero_drop(a_zero_drop)
  );
  bitscan_encoder #(.N(16), .MSB_FIRST(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_vec(b_in_vec),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_idx(b_out_idx), .out_last(b_out_last),
    .out_remain(b_out_remain), .zero_drop(b_zero_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (a_out_valid) begin
    if (qa.size() == 0) check("a_extra_beat", 1, 0);
    else begin
      check("a_idx", 32'(a_out_idx), qa[0].idx);
      check("a_remain", 32'(a_out_remain), qa[0].rem);
      check("a_last", 32'(a_out_last), 32'(qa[0].last));
      if (a_out_ready) void'(qa.pop_front());
    end
  end

  always @(negedge clk) if (b_out_valid) begin
    if (qb.size() == 0) check("b_extra_beat", 1, 0);
    else begin
      check("b_idx", 32'(b_out_idx), qb[0].idx);
      check("b_remain", 32'(b_out_remain), qb[0].rem);
      check("b_last", 32'(b_out_last), 32'(qb[0].last));
      if (b_out_ready) void'(qb.pop_front());
    end
  end

  task automatic send_a(input logic [7:0] v);
    int c = $countones(v);
    for (int i = 0; i < 8; i++) if (v[i]) begin
      qa.push_back('{i, c, c == 1});
      c--;
    end
    check("a_ready_pre", 32'(a_in_ready), 1);
    a_in_vec = v;
    a_in_valid = 1;
    @(posedge clk);
    #1 a_in_valid = 0;
  endtask

  task automatic send_b(input logic [15:0] v);
    int c = $countones(v);
    for (int i = 15; i >= 0; i--) if (v[i]) begin
      qb.push_back('{i, c, c == 1});
      c--;
    end
    check("b_ready_pre", 32'(b_in_ready), 1);
    b_in_vec = v;
    b_in_valid = 1;
    @(posedge clk);
    #1 b_in_valid = 0;
  endtask

  task automatic wait_a(input bit rnd);
    int n = 0;
    while ((qa.size() != 0 || !a_in_ready) && n < 300) begin
      if (rnd) a_out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1 n++;
    end
    a_out_ready = 1;
    check("a_drain", 32'(n < 300), 1);
  endtask

  task automatic wait_b(input bit rnd);
    int n = 0;
    while ((qb.size() != 0 || !b_in_ready) && n < 300) begin
      if (rnd) b_out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1 n++;
    end
    b_out_ready = 1;
    check("b_drain", 32'(n < 300), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(a_in_ready), 1);
    check("rst_out_valid", 32'(a_out_valid), 0);
    check("rst_out_idx", 32'(a_out_idx), 0);
    check("rst_out_remain", 32'(a_out_remain), 0);
    check("rst_out_last", 32'(a_out_last), 0);
    check("rst_zero_drop", 32'(a_zero_drop), 0);
    check("rst_b_out_valid", 32'(b_out_valid), 0);
    rst_n = 1;
    @(posedge clk);
    #1;
    send_a(8'b0000_0001);
    check("single_busy", 32'(a_in_ready), 0);
    check("single_valid", 32'(a_out_valid), 1);
    @(posedge clk);
    #1;
    check("single_ready_back", 32'(a_in_ready), 1);
    check("single_valid_off", 32'(a_out_valid), 0);
    send_a(8'b1001_0110);
    wait_a(0);
    send_a(8'b1001_0110);
    @(posedge clk);
    #1 a_out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    check("stall_idx", 32'(a_out_idx), 2);
    check("stall_remain", 32'(a_out_remain), 3);
    a_out_ready = 1;
    wait_a(0);
    send_b(16'h0081);
    b_in_vec = 16'hFFFF;
    b_in_valid = 1;
    @(posedge clk);
    #1 b_in_valid = 0;
    wait_b(0);
    send_b(16'hFFFF);
    check("ones_remain16", 32'(b_out_remain), 16);
    check("ones_idx15", 32'(b_out_idx), 15);
    wait_b(0);
    send_a(8'h00);
    check("zero_pulse", 32'(a_zero_drop), 1);
    check("zero_no_valid", 32'(a_out_valid), 0);
    check("zero_ready", 32'(a_in_ready), 1);
    @(posedge clk);
    #1;
    check("zero_pulse_end", 32'(a_zero_drop), 0);
    check("zero_no_valid2", 32'(a_out_valid), 0);
    send_a(8'b1111_0000);
    repeat (2) @(posedge clk);
    #1;
    check("mid_idx", 32'(a_out_idx), 6);
    #2 rst_n = 0;
    #1;
    check("arst_valid", 32'(a_out_valid), 0);
    check("arst_idx", 32'(a_out_idx), 0);
    check("arst_remain", 32'(a_out_remain), 0);
    check("arst_ready", 32'(a_in_ready), 1);
    qa.delete();
    @(posedge clk);
    #1 rst_n = 1;
    check("post_rst_ready", 32'(a_in_ready), 1);
    send_a(8'b0000_0100);
    check("post_rst_idx", 32'(a_out_idx), 2);
    check("post_rst_last", 32'(a_out_last), 1);
    wait_a(0);
    for (int k = 0; k < 20; k++) begin
      send_a(8'($urandom));
      wait_a(1);
      send_b(16'($urandom));
      wait_b(1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
